// File: rtl/spi_frame_parser.sv
// ============================================================================
// Module      : spi_frame_parser
// Description : Parses SPI grid/move frames into grid writes and move words,
//               with XOR checksum and inter-byte timeout checks.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module spi_frame_parser #(
    parameter int unsigned GRID_BYTES  = 16,
    parameter int unsigned MAX_MOVES   = 220,
    parameter logic [7:0]  GRID_HEADER = 8'hD5,
    parameter logic [7:0]  MOVE_HEADER = 8'hEA,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          grid_we,
    output logic [$clog2(GRID_BYTES)-1:0] grid_addr,
    output logic [7:0]                    grid_data,
    output logic                          move_valid,
    output logic [7:0]                    move_idx,
    output logic [15:0]                   move_data,
    output logic                          frame_done,
    output logic                          frame_type,
    output logic                          frame_err,
    output logic [1:0]                    err_code,
    output logic                          busy
);

    localparam int unsigned AW = $clog2(GRID_BYTES);
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [AW-1:0] c_GRID_LAST = AW'(GRID_BYTES - 1);
    localparam logic [7:0]    c_MAX_MOVES = 8'(MAX_MOVES);
    localparam logic [TW-1:0] c_TO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GRID_PAY = 3'd1,
        S_MOVE_CNT = 3'd2,
        S_MOVE_HI  = 3'd3,
        S_MOVE_LO  = 3'd4,
        S_CHECK    = 3'd5
    } state_t;

    state_t          r_state, w_state;
    logic [AW-1:0]   r_cnt, w_cnt;
    logic [7:0]      r_n, w_n;
    logic [7:0]      r_idx, w_idx;
    logic [7:0]      r_hi, w_hi;
    logic [7:0]      r_csum, w_csum;
    logic [TW-1:0]   r_idle, w_idle;
    logic            w_grid_we, w_move_valid, w_frame_done, w_frame_err, w_frame_type;
    logic [AW-1:0]   w_grid_addr;
    logic [7:0]      w_grid_data, w_move_idx;
    logic [15:0]     w_move_data;
    logic [1:0]      w_err_code;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt;
        w_n          = r_n;
        w_idx        = r_idx;
        w_hi         = r_hi;
        w_csum       = r_csum ^ in_data;
        w_idle       = '0;
        w_grid_we    = 1'b0;
        w_grid_addr  = grid_addr;
        w_grid_data  = grid_data;
        w_move_valid = 1'b0;
        w_move_idx   = move_idx;
        w_move_data  = move_data;
        w_frame_done = 1'b0;
        w_frame_err  = 1'b0;
        w_frame_type = frame_type;
        w_err_code   = err_code;

        if (in_valid) begin
            unique case (r_state)
                S_IDLE: begin
                    w_csum = in_data;
                    if (in_data == GRID_HEADER) begin
                        w_state      = S_GRID_PAY;
                        w_cnt        = '0;
                        w_frame_type = 1'b0;
                    end else if (in_data == MOVE_HEADER) begin
                        w_state      = S_MOVE_CNT;
                        w_frame_type = 1'b1;
                    end else begin
                        w_frame_err = 1'b1;
                        w_err_code  = 2'd0;
                    end
                end
                S_GRID_PAY: begin
                    w_grid_we   = 1'b1;
                    w_grid_addr = r_cnt;
                    w_grid_data = in_data;
                    w_cnt       = r_cnt + 1'b1;
                    if (r_cnt == c_GRID_LAST) begin
                        w_state = S_CHECK;
                    end
                end
                S_MOVE_CNT: begin
                    if (in_data == 8'd0 || in_data > c_MAX_MOVES) begin
                        w_frame_err = 1'b1;
                        w_err_code  = 2'd1;
                        w_state     = S_IDLE;
                    end else begin
                        w_n     = in_data;
                        w_idx   = 8'd0;
                        w_state = S_MOVE_HI;
                    end
                end
                S_MOVE_HI: begin
                    w_hi    = in_data;
                    w_state = S_MOVE_LO;
                end
                S_MOVE_LO: begin
                    w_move_valid = 1'b1;
                    w_move_idx   = r_idx;
                    w_move_data  = {r_hi, in_data};
                    w_idx        = r_idx + 8'd1;
                    w_state      = (r_idx == r_n - 8'd1) ? S_CHECK : S_MOVE_HI;
                end
                S_CHECK: begin
                    if (in_data == r_csum) begin
                        w_frame_done = 1'b1;
                    end else begin
                        w_frame_err = 1'b1;
                        w_err_code  = 2'd2;
                    end
                    w_state = S_IDLE;
                end
                default: w_state = S_IDLE;
            endcase
        end else begin
            w_csum = r_csum;
            if (r_state != S_IDLE) begin
                // A byte in the terminal-count cycle takes the branch above, so it always wins.
                if (r_idle == c_TO_LAST) begin
                    w_frame_err = 1'b1;
                    w_err_code  = 2'd3;
                    w_state     = S_IDLE;
                end else begin
                    w_idle = r_idle + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt      <= '0;
            r_n        <= '0;
            r_idx      <= '0;
            r_hi       <= '0;
            r_csum     <= '0;
            r_idle     <= '0;
            grid_we    <= 1'b0;
            grid_addr  <= '0;
            grid_data  <= '0;
            move_valid <= 1'b0;
            move_idx   <= '0;
            move_data  <= '0;
            frame_done <= 1'b0;
            frame_type <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= '0;
        end else begin
            r_cnt      <= w_cnt;
            r_n        <= w_n;
            r_idx      <= w_idx;
            r_hi       <= w_hi;
            r_csum     <= w_csum;
            r_idle     <= w_idle;
            grid_we    <= w_grid_we;
            grid_addr  <= w_grid_addr;
            grid_data  <= w_grid_data;
            move_valid <= w_move_valid;
            move_idx   <= w_move_idx;
            move_data  <= w_move_data;
            frame_done <= w_frame_done;
            frame_type <= w_frame_type;
            frame_err  <= w_frame_err;
            err_code   <= w_err_code;
        end
    end

    assign busy = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: doc/spi_frame_parser.md
Name: spi_frame_parser

Overview:
Sits between the SPI slave receiver and the TPU core. It consumes the raw received byte stream and recognises grid and move frames by their header bytes. It unpacks each payload into byte-addressed grid writes or 16-bit move words, and checks an XOR checksum and an inter-byte timeout. It reports frame completion or a coded error to the TPU control FSM.

Parameters:
GRID_BYTES, 16, grid payload length in bytes (8x8 cells, 2 bits per cell)
MAX_MOVES, 220, maximum move count accepted in a move frame
GRID_HEADER, 8'hD5, first byte of a grid frame
MOVE_HEADER, 8'hEA, first byte of a move frame
TIMEOUT, 1024, clk cycles allowed between bytes inside a frame before abort

Ports:
clk  in  1  system clock
nrst  in  1  asynchronous active-low reset
in_valid  in  1  one-cycle strobe: in_data holds a received byte
in_data  in  8  received byte
grid_we  out  1  one-cycle grid byte write strobe
grid_addr  out  $clog2(GRID_BYTES)  grid byte index, 0..GRID_BYTES-1
grid_data  out  8  grid byte
move_valid  out  1  one-cycle move word strobe
move_idx  out  8  move index, 0..N-1
move_data  out  16  move word, first byte received is [15:8]
frame_done  out  1  one-cycle pulse: frame accepted, checksum good
frame_type  out  1  type of last done or errored frame: 0 = grid, 1 = move
frame_err  out  1  one-cycle error pulse
err_code  out  2  held with frame_err: 0 = bad header, 1 = bad count, 2 = checksum, 3 = timeout
busy  out  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: single clock domain, clk. nrst is asynchronous, active-low. In reset, state = IDLE and all outputs and counters are 0.
- Outputs are registered. Every strobe asserts exactly one cycle after the in_valid cycle that caused it. in_valid may be asserted on back-to-back cycles.
- Running checksum csum:
  - The header byte loads csum = header.
  - Every later byte does csum ^= byte.
  - A frame is good when the final checksum byte equals the XOR of all preceding bytes of the frame.
- IDLE:
  - Byte = GRID_HEADER: go to GRID_PAY, cnt = 0, frame_type = 0.
  - Byte = MOVE_HEADER: go to MOVE_CNT, frame_type = 1.
  - Any other byte: discard it, frame_err with err_code 0, stay in IDLE.
- GRID_PAY:
  - Each byte produces grid_we, grid_addr = cnt, grid_data = byte, then cnt++.
  - After byte GRID_BYTES-1, go to CHECK.
- MOVE_CNT:
  - Byte N with 1 <= N <= MAX_MOVES: latch N, idx = 0, go to MOVE_HI.
  - N = 0 or N > MAX_MOVES: frame_err with err_code 1, go to IDLE. No moves are emitted.
- MOVE_HI: latch the byte as the high byte, go to MOVE_LO.
- MOVE_LO:
  - Emit move_valid with move_idx = idx and move_data = {hi, byte}, then idx++.
  - If idx was N-1, go to CHECK; otherwise go to MOVE_HI.
- CHECK:
  - Byte == csum: frame_done.
  - Otherwise: frame_err with err_code 2.
  - Either way, go to IDLE.
- Writes already emitted are not retracted. The TPU discards the buffered frame on frame_err.
- Timeout:
  - An idle counter clears on every in_valid and counts while state != IDLE.
  - When it reaches TIMEOUT-1 with no byte: frame_err with err_code 3, go to IDLE.
  - If in_valid arrives in that same cycle, the byte wins and no timeout fires.
- A header value arriving mid-frame is treated as ordinary data. There is no resync inside a frame.
- frame_done and frame_err are never asserted in the same cycle.
- The 8-bit idx is sufficient because MAX_MOVES <= 255.
- Reset asserted mid-frame: immediate return to IDLE, all strobes 0, no pulse emitted.

Test Plan:
- Grid frame: header D5, bytes 00..0F, checksum = D5 ^ (XOR of 00..0F) = D5 -> 16 grid_we with addr 0..15 and data 00..0F, then frame_done with frame_type 0.
- Move frame: EA, 02, 12 34, AB CD, checksum = EA^02^12^34^AB^CD -> move 0 = 1234, move 1 = ABCD, frame_done with frame_type 1; repeat with every in_valid back-to-back and get the same result.
- Move count 00 and count DD (221) -> frame_err with err_code 1, no move_valid; a following valid grid frame parses normally.
- Grid frame with the checksum byte flipped -> 16 writes, then frame_err with err_code 2 and no frame_done.
- Stray byte 55 in IDLE -> frame_err with err_code 0; a grid frame stalled after 3 bytes -> frame_err with err_code 3 exactly TIMEOUT cycles after the last byte, then busy = 0.
- nrst pulsed low mid move frame -> all outputs 0, state IDLE; a following complete frame is parsed correctly.
